// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and sizing helpers for the data-memory responder
//
// Holds the RV32I load/store funct3 codes, the responder state encoding and
// pure functions for access checking, load extension and store merging.
// No ports.

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    // 1 when the access is misaligned or its funct3 is not a legal load/store.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic e;
        e = 1'b1;
        if (we) begin
            case (f3)
                F3_B:    e = 1'b0;
                F3_H:    e = off[0];
                F3_W:    e = (off != 2'b00);
                default: e = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_B, F3_BU: e = 1'b0;
                F3_H, F3_HU: e = off[0];
                F3_W:        e = (off != 2'b00);
                default:     e = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Select the addressed byte/halfword of a word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Insert the low byte/halfword of the store data into the old word.
    function automatic logic [31:0] merge_store(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] r;
        r = old;
        case (f3)
            F3_B: r[{off, 3'b000} +: 8] = wd[7:0];
            F3_H: begin
                if (off[1]) r[31:16] = wd[15:0];
                else        r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word-wide synchronous RAM with registered read data
//
// DEPTH_WORDS x 32 storage, one index shared by the read and write ports.
// Ports:
//   clk      clock
//   re_i     read enable; rdata_o updates on the next rising edge
//   we_i     write enable; mem[idx_i] <= wdata_i on the rising edge
//   idx_i    word index
//   wdata_i  write data
//   rdata_o  registered read data
// Contents are not reset.

module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder between the CPU and word RAM
//
// Accepts one byte-addressed RV32I load/store at a time, performs sub-word
// extension and read-modify-write merging, and returns a registered response
// two edges after acceptance.
// Optional feature macro: DMEM_MMIO_EN (one 32-bit output register at MMIO_ADDR).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_we, req_funct3            store flag and RV32I funct3
//   req_addr, req_wdata           byte address and store data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            extended load data (0 for stores/errors), error flag
//   io_out                        low half of the MMIO register (0 when compiled out)

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] io_out
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [AW-1:0] ram_idx;
    logic          ram_re;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic [31:0]   rd_word;
    logic [31:0]   merged;
    logic          acc_err;
    logic          mmio_hit;

    // The read is launched from the live request in the accept cycle; after
    // that the captured address drives the index so the RD write hits the
    // same word that was read.
    assign ram_idx = (state_q == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
    assign ram_re  = (state_q == IDLE) && req_valid;

    assign acc_err = access_err(we_q, f3_q, addr_q[1:0]);
    assign merged  = merge_store(rd_word, wdata_q, f3_q, addr_q[1:0]);

    // Decoded from state so an asynchronous reset kills a pending write at once.
    assign ram_we  = (state_q == RD) && we_q && !acc_err && !mmio_hit;

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;

    assign mmio_hit = (addr_q[31:2] == MMIO_ADDR[31:2]);
    assign rd_word  = mmio_hit ? mmio_q : ram_rdata;
    assign io_out   = mmio_q[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_q <= 32'h0;
        end else if ((state_q == RD) && we_q && !acc_err && mmio_hit) begin
            mmio_q <= merged;
        end
    end
`else
    logic unused_mmio;

    assign mmio_hit    = 1'b0;
    assign rd_word     = ram_rdata;
    assign io_out      = 16'h0;
    assign unused_mmio = ^{MMIO_ADDR, addr_q[31:AW+2]};
`endif

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .idx_i   (ram_idx),
        .wdata_i (merged),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= RD;
                    end
                end
                RD: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= acc_err;
                    rsp_rdata_q <= (acc_err || we_q) ? 32'h0
                                 : load_extend(rd_word, f3_q, addr_q[1:0]);
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
